// File: rtl/fir_mac_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC scheduler.
// Widths are derived from the instantiating module's parameters via the helper functions.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TAPS   = 4;
  localparam int DEF_DW     = 16;
  localparam int DEF_CW     = 16;

  // Accumulator is wide enough that TAPS full-precision products never overflow.
  localparam int ACC_W = DEF_DW + DEF_CW + $clog2(DEF_TAPS);
  localparam int CH_W  = $clog2(DEF_NUM_CH);

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Clamp a sign-extended value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] value, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Request, coefficient-configuration and result signals of the FIR MAC scheduler.
// master = channel front ends / configuration side, slave = the scheduler.
interface fir_mac_scheduler_if
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TAPS   = DEF_TAPS,
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW
);
  localparam int IF_CH_W  = $clog2(NUM_CH);
  localparam int IF_TAP_W = $clog2(TAPS);

  logic [NUM_CH-1:0]      req_valid;
  logic [NUM_CH*DW-1:0]   req_data;
  logic [NUM_CH-1:0]      req_ready;
  logic                   coef_we;
  logic [IF_TAP_W-1:0]    coef_addr;
  logic signed [CW-1:0]   coef_wdata;
  logic                   coef_err;
  logic                   out_valid;
  logic [IF_CH_W-1:0]     out_ch;
  logic signed [DW-1:0]   out_data;
  logic                   busy;

  modport master (
    output req_valid, req_data, coef_we, coef_addr, coef_wdata,
    input  req_ready, coef_err, out_valid, out_ch, out_data, busy
  );

  modport slave (
    input  req_valid, req_data, coef_we, coef_addr, coef_wdata,
    output req_ready, coef_err, out_valid, out_ch, out_data, busy
  );

endinterface

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid channel after last_grant, wrapping around.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int A_CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [A_CH_W-1:0] i_last,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [A_CH_W-1:0] o_grant_idx,
  output logic              o_grant_valid
);

  int w_idx;

  always_comb begin
    o_grant_oh    = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = (int'(i_last) + i) % NUM_CH;
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid      = 1'b1;
        o_grant_idx        = A_CH_W'(w_idx);
        o_grant_oh[w_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// One serial MAC shared round-robin across NUM_CH FIR channels with a common coefficient set.
// Results are saturated to DW bits and strobed with their channel tag.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TAPS   = DEF_TAPS,
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW,
  parameter int SHIFT  = 0
) (
  input logic               clk,
  input logic               reset_n,
  fir_mac_scheduler_if.slave bus
);

  localparam int L_ACC_W = acc_width(DW, CW, TAPS);
  localparam int L_CH_W  = $clog2(NUM_CH);
  localparam int TAP_W   = $clog2(TAPS);
  localparam int PW      = DW + CW;

  state_t                  r_state;
  logic [L_CH_W-1:0]       r_last_grant;
  logic [L_CH_W-1:0]       r_cur_ch;
  logic [TAP_W-1:0]        r_tap;
  logic signed [L_ACC_W-1:0] r_acc;
  logic signed [CW-1:0]    r_coef [TAPS];
  logic signed [DW-1:0]    r_hist [NUM_CH][TAPS];
  logic                    r_out_valid;
  logic [L_CH_W-1:0]       r_out_ch;
  logic signed [DW-1:0]    r_out_data;
  logic                    r_busy;
  logic                    r_coef_err;

  logic [NUM_CH-1:0]       w_grant_oh;
  logic [L_CH_W-1:0]       w_grant_idx;
  logic                    w_grant_valid;
  logic signed [DW-1:0]    w_sample;
  logic signed [CW-1:0]    w_coef;
  logic signed [PW-1:0]    w_sample_ext;
  logic signed [PW-1:0]    w_coef_ext;
  logic signed [PW-1:0]    w_prod;
  logic signed [L_ACC_W-1:0] w_acc_sum;
  logic signed [L_ACC_W-1:0] w_shifted;

  fir_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req         (bus.req_valid),
    .i_last        (r_last_grant),
    .o_grant_oh    (w_grant_oh),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Operands are sign-extended to the full product width so the multiply is exact.
  assign w_sample     = r_hist[r_cur_ch][r_tap];
  assign w_coef       = r_coef[r_tap];
  assign w_sample_ext = {{CW{w_sample[DW-1]}}, w_sample};
  assign w_coef_ext   = {{DW{w_coef[CW-1]}}, w_coef};
  assign w_prod       = w_sample_ext * w_coef_ext;
  assign w_acc_sum    = r_acc + {{(L_ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_shifted    = w_acc_sum >>> SHIFT;

  assign bus.req_ready = (r_state == IDLE) ? w_grant_oh : '0;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.coef_err  = r_coef_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= L_CH_W'(NUM_CH - 1);
      r_cur_ch     <= '0;
      r_tap        <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_coef_err   <= 1'b0;
      for (int t = 0; t < TAPS; t++) begin
        r_coef[t] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          r_hist[c][t] <= '0;
        end
      end
    end else begin
      r_out_valid <= 1'b0;
      r_coef_err  <= 1'b0;

      // A write landing on a grant edge still reaches the computation that starts next cycle.
      if (bus.coef_we) begin
        if (r_state == IDLE) r_coef[bus.coef_addr] <= bus.coef_wdata;
        else                 r_coef_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              r_hist[w_grant_idx][k] <= r_hist[w_grant_idx][k-1];
            end
            r_hist[w_grant_idx][0] <= bus.req_data[w_grant_idx*DW +: DW];
            r_cur_ch     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_tap        <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b1;
            r_state      <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_sum;
          r_tap <= r_tap + 1'b1;
          if (r_tap == TAP_W'(TAPS - 1)) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
            r_out_ch    <= r_cur_ch;
            r_out_data  <= DW'(sat_dw({{(64-L_ACC_W){w_shifted[L_ACC_W-1]}}, w_shifted}, DW));
          end
        end
        OUT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: reset, FIR math, round-robin, saturation,
// dropped coefficient writes and mid-operation reset, with hand-computed expectations.
module tb_fir_mac_scheduler;

  localparam int NUM_CH = 4;
  localparam int TAPS   = 4;
  localparam int DW     = 16;
  localparam int CW     = 16;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;
  int   err_cnt;

  fir_mac_scheduler_if #(.NUM_CH(NUM_CH), .TAPS(TAPS), .DW(DW), .CW(CW)) bus ();

  fir_mac_scheduler #(.NUM_CH(NUM_CH), .TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.coef_err) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int addr, input logic signed [15:0] val);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 2'(addr);
    bus.coef_wdata = val;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic wr_3773();
    wr_coef(0, 16'sd3);
    wr_coef(1, 16'sd7);
    wr_coef(2, 16'sd7);
    wr_coef(3, 16'sd3);
  endtask

  // Wait (bounded) for out_valid; lat counts cycles since the req_ready cycle.
  task automatic wait_out(input bit inj, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      if (inj && lat == 2) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 2'd0;
        bus.coef_wdata = 16'sd100;
      end else begin
        bus.coef_we = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input logic signed [15:0] s, input int exp,
                      input string tag, input bit inj);
    int guard;
    int lat;
    bus.req_data[ch*DW +: DW] = s;
    bus.req_valid[ch]         = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready[ch] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << ch));
    @(posedge clk);
    #1;
    bus.req_valid[ch] = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'sd1);
    wait_out(inj, lat);
    $display("txn %s ch=%0d sample=%0d out_ch=%0d out=%0d lat=%0d",
             tag, ch, s, bus.out_ch, bus.out_data, lat);
    check({tag, "_lat"}, lat, TAPS + 1);
    check({tag, "_ch"}, 32'(bus.out_ch), ch);
    check({tag, "_data"}, 32'(bus.out_data), exp);
    @(posedge clk);
    #1;
    check({tag, "_strobe1"}, 32'(bus.out_valid), 32'sd0);
    check({tag, "_hold"}, 32'(bus.out_data), exp);
  endtask

  int rr_exp_data [5] = '{30, 60, 90, 120, 100};
  int e0;
  int seen;

  initial begin
    n_total = 0;
    n_bad   = 0;
    err_cnt = 0;

    // Reset state and zero-coefficient result
    do_reset();
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_ch", 32'(bus.out_ch), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.coef_err), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    send(0, 16'sd500, 0, "zero_coef", 1'b0);

    // Basic FIR on channel 0
    do_reset();
    e0 = err_cnt;
    wr_3773();
    check("idle_wr_no_err", err_cnt - e0, 0);
    send(0, 16'sd100, 300,  "fir1", 1'b0);
    send(0, 16'sd100, 1000, "fir2", 1'b0);
    send(0, 16'sd100, 1700, "fir3", 1'b0);
    send(0, 16'sd100, 2000, "fir4", 1'b0);

    // Round-robin with all channels continuously valid
    do_reset();
    wr_3773();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.req_data[c*DW +: DW] = 16'(10 * (c + 1));
    end
    bus.req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      int guard;
      int lat;
      guard = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'(1 << (g % NUM_CH)));
      @(posedge clk);
      #1;
      if (g == 4) bus.req_valid = '0;
      wait_out(1'b0, lat);
      $display("txn rr%0d out_ch=%0d out=%0d lat=%0d", g, bus.out_ch, bus.out_data, lat);
      check($sformatf("rr_ch%0d", g), 32'(bus.out_ch), g % NUM_CH);
      check($sformatf("rr_data%0d", g), 32'(bus.out_data), rr_exp_data[g]);
    end

    // Channel isolation
    do_reset();
    wr_3773();
    send(1, 16'sd10, 30, "iso_ch1", 1'b0);
    send(0, 16'sd100, 300, "iso_ch0", 1'b0);

    // Saturation at both rails
    do_reset();
    for (int t = 0; t < TAPS; t++) wr_coef(t, 16'sh7FFF);
    send(2, 16'sd32767, 32767, "sat_pos", 1'b0);
    send(3, -16'sd32768, -32768, "sat_neg", 1'b0);

    // Coefficient write dropped while busy
    do_reset();
    wr_3773();
    e0 = err_cnt;
    send(0, 16'sd100, 300, "wr_busy", 1'b1);
    check("coef_err_pulses", err_cnt - e0, 1);
    send(1, 16'sd10, 30, "after_drop", 1'b0);

    // Reset during MAC aborts the computation
    do_reset();
    wr_3773();
    bus.req_data[0 +: DW] = 16'sd50;
    bus.req_valid[0]      = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40 && !bus.req_ready[0]; i++) @(negedge clk);
    check("mid_ready", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("mid_no_out", seen, 0);
    check("mid_busy_after", 32'(bus.busy), 0);
    wr_3773();
    send(0, 16'sd100, 300, "post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
